// File: rtl/qsfp_mgmt_pkg.sv
`default_nettype none
// qsfp_mgmt_pkg: shared state encoding and timing defaults for the QSFP management controller.
package qsfp_mgmt_pkg;

  localparam int unsigned DEBOUNCE_CYC_DEF   = 50000;
  localparam int unsigned RST_ASSERT_CYC_DEF = 500;
  localparam int unsigned INIT_WAIT_CYC_DEF  = 100000000;
  localparam int unsigned CNT_W              = 27;

  typedef enum logic [1:0] {
    ST_ABSENT     = 2'd0,
    ST_RST_ASSERT = 2'd1,
    ST_INIT_WAIT  = 2'd2,
    ST_READY      = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// sync_debounce: 2-flop synchronizer followed by a stability-counter debouncer.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  localparam int unsigned   CW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYC-th consecutive differing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/qsfp_mgmt_ctrl.sv
`default_nettype none
// qsfp_mgmt_ctrl: QSFP presence debounce, reset/init sequencing, interrupt and insertion tracking.
module qsfp_mgmt_ctrl
  import qsfp_mgmt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
  parameter int unsigned RST_ASSERT_CYC = RST_ASSERT_CYC_DEF,
  parameter int unsigned INIT_WAIT_CYC  = INIT_WAIT_CYC_DEF
) (
  input  logic       clk_50,
  input  logic       cpu_resetn,
  input  logic       qsfp_mod_prsn,
  input  logic       qsfp_interruptn,
  input  logic       sw_reset_req,
  input  logic       lp_mode_req,
  input  logic       int_clear,
  output logic       qsfp_rstn,
  output logic       qsfp_lp_mode,
  output logic       qsfp_mod_seln,
  output logic       mod_present,
  output logic       mod_ready,
  output logic       int_pending,
  output logic [1:0] state,
  output logic [7:0] insert_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);

  logic             prsn_deb;
  logic             int_meta_q, int_sync_q;
  logic             present_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       insert_q, insert_d;
  logic             rstn_q, rstn_d;
  logic             lp_q, lp_d;
  logic             seln_q, seln_d;
  logic             ready_q, ready_d;
  logic             int_q, int_d;

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_prsn_deb (
    .clk_i   (clk_50),
    .rst_ni  (cpu_resetn),
    .async_i (qsfp_mod_prsn),
    .level_o (prsn_deb)
  );

  // Loss of presence overrides every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    insert_d = insert_q;
    if (!present_q) begin
      state_d = ST_ABSENT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ABSENT: begin
          state_d = ST_RST_ASSERT;
          cnt_d   = '0;
          if (insert_q != 8'hFF) insert_d = insert_q + 8'd1;
        end
        ST_RST_ASSERT: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_INIT_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_INIT_WAIT: begin
          if (sw_reset_req) begin
            state_d = ST_RST_ASSERT;
            cnt_d   = '0;
          end else if (cnt_q == INIT_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (sw_reset_req) begin
            state_d = ST_RST_ASSERT;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_ABSENT;
      endcase
    end
  end

  // Module-facing outputs are decoded from the next state so they align with state.
  always_comb begin
    rstn_d  = (state_d == ST_INIT_WAIT) || (state_d == ST_READY);
    seln_d  = (state_d != ST_READY);
    ready_d = (state_d == ST_READY);
    lp_d    = !((state_d == ST_READY) && !lp_mode_req);
    int_d   = int_q;
    if (state_d == ST_ABSENT) begin
      int_d = 1'b0;
    end else if ((state_q == ST_READY) && !int_sync_q) begin
      int_d = 1'b1;
    end else if (int_clear) begin
      int_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      int_meta_q <= 1'b1;
      int_sync_q <= 1'b1;
      present_q  <= 1'b0;
      state_q    <= ST_ABSENT;
      cnt_q      <= '0;
      insert_q   <= '0;
      rstn_q     <= 1'b0;
      lp_q       <= 1'b1;
      seln_q     <= 1'b1;
      ready_q    <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      int_meta_q <= qsfp_interruptn;
      int_sync_q <= int_meta_q;
      present_q  <= ~prsn_deb;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      insert_q   <= insert_d;
      rstn_q     <= rstn_d;
      lp_q       <= lp_d;
      seln_q     <= seln_d;
      ready_q    <= ready_d;
      int_q      <= int_d;
    end
  end

  assign qsfp_rstn     = rstn_q;
  assign qsfp_lp_mode  = lp_q;
  assign qsfp_mod_seln = seln_q;
  assign mod_present   = present_q;
  assign mod_ready     = ready_q;
  assign int_pending   = int_q;
  assign state         = state_q;
  assign insert_cnt    = insert_q;

endmodule
`default_nettype wire

// File: tb/tb_qsfp_mgmt_ctrl.sv
`default_nettype none
// tb_qsfp_mgmt_ctrl: directed stimulus with a cycle-level reference model and per-cycle compare.
module tb_qsfp_mgmt_ctrl;

  localparam int DEB  = 4;
  localparam int RSTC = 5;
  localparam int INIT = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prsn, intn, sw, lpreq, iclr;
  logic       qsfp_rstn, qsfp_lp_mode, qsfp_mod_seln, mod_present, mod_ready, int_pending;
  logic [1:0] state;
  logic [7:0] insert_cnt;

  int total = 0;
  int bad   = 0;

  qsfp_mgmt_ctrl #(
    .DEBOUNCE_CYC   (DEB),
    .RST_ASSERT_CYC (RSTC),
    .INIT_WAIT_CYC  (INIT)
  ) dut (
    .clk_50          (clk),
    .cpu_resetn      (rst_n),
    .qsfp_mod_prsn   (prsn),
    .qsfp_interruptn (intn),
    .sw_reset_req    (sw),
    .lp_mode_req     (lpreq),
    .int_clear       (iclr),
    .qsfp_rstn       (qsfp_rstn),
    .qsfp_lp_mode    (qsfp_lp_mode),
    .qsfp_mod_seln   (qsfp_mod_seln),
    .mod_present     (mod_present),
    .mod_ready       (mod_ready),
    .int_pending     (int_pending),
    .state           (state),
    .insert_cnt      (insert_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: input history, run-length debounce, countdown timers.
  bit m_ps1, m_ps2, m_deb, m_present, m_is1, m_is2, m_int;
  bit m_rstn, m_lp, m_seln, m_ready;
  int m_run, m_state, m_left, m_ins;

  always @(posedge clk or negedge rst_n) begin : model
    int ns, nl, nins, nrun;
    bit ndeb, nint;
    if (!rst_n) begin
      m_ps1 <= 1; m_ps2 <= 1; m_deb <= 1; m_run <= 0; m_present <= 0;
      m_is1 <= 1; m_is2 <= 1; m_int <= 0; m_state <= 0; m_left <= 0; m_ins <= 0;
      m_rstn <= 0; m_lp <= 1; m_seln <= 1; m_ready <= 0;
    end else begin
      ndeb = m_deb;
      nrun = 0;
      if (m_ps2 != m_deb) begin
        nrun = m_run + 1;
        if (nrun == DEB) begin ndeb = m_ps2; nrun = 0; end
      end
      ns = m_state; nl = m_left; nins = m_ins;
      if (!m_present) ns = 0;
      else if (m_state == 0) begin
        ns = 1; nl = RSTC; nins = (m_ins < 255) ? m_ins + 1 : 255;
      end else if (m_state == 1) begin
        if (m_left == 1) begin ns = 2; nl = INIT; end else nl = m_left - 1;
      end else if (sw) begin
        ns = 1; nl = RSTC;
      end else if (m_state == 2) begin
        if (m_left == 1) ns = 3; else nl = m_left - 1;
      end
      nint = m_int;
      if (ns == 0) nint = 0;
      else if (m_state == 3 && !m_is2) nint = 1;
      else if (iclr) nint = 0;
      m_ps1 <= prsn; m_ps2 <= m_ps1; m_deb <= ndeb; m_run <= nrun;
      m_present <= !m_deb;
      m_is1 <= intn; m_is2 <= m_is1; m_int <= nint;
      m_state <= ns; m_left <= nl; m_ins <= nins;
      m_rstn  <= (ns == 2 || ns == 3);
      m_seln  <= (ns != 3);
      m_ready <= (ns == 3);
      m_lp    <= !(ns == 3 && !lpreq);
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("qsfp_rstn", 32'(qsfp_rstn), 32'(m_rstn));
    chk("qsfp_lp_mode", 32'(qsfp_lp_mode), 32'(m_lp));
    chk("qsfp_mod_seln", 32'(qsfp_mod_seln), 32'(m_seln));
    chk("mod_present", 32'(mod_present), 32'(m_present));
    chk("mod_ready", 32'(mod_ready), 32'(m_ready));
    chk("int_pending", 32'(int_pending), 32'(m_int));
    chk("insert_cnt", 32'(insert_cnt), 32'(m_ins));
  end

  initial begin
    rst_n = 0; prsn = 1; intn = 1; sw = 0; lpreq = 0; iclr = 0;
    tick(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_rstn", 32'(qsfp_rstn), 0);
    chk("rst_lp", 32'(qsfp_lp_mode), 1);
    chk("rst_seln", 32'(qsfp_mod_seln), 1);
    chk("rst_present", 32'(mod_present), 0);
    chk("rst_insert", 32'(insert_cnt), 0);
    rst_n = 1;
    tick(3);

    // Three-cycle presence glitch is rejected.
    prsn = 0; tick(3); prsn = 1; tick(10);
    chk("glitch_present", 32'(mod_present), 0);
    chk("glitch_insert", 32'(insert_cnt), 0);

    // Insertion timeline, edges numbered from the first sampling edge.
    prsn = 0;
    tick(6);  chk("ins_e5_present", 32'(mod_present), 0);
    tick(1);  chk("ins_e6_present", 32'(mod_present), 1);
              chk("ins_e6_state", 32'(state), 0);
    tick(1);  chk("ins_e7_state", 32'(state), 1);
              chk("ins_e7_insert", 32'(insert_cnt), 1);
              chk("ins_e7_rstn", 32'(qsfp_rstn), 0);
    tick(4);  chk("ins_e11_state", 32'(state), 1);
    tick(1);  chk("ins_e12_state", 32'(state), 2);
              chk("ins_e12_rstn", 32'(qsfp_rstn), 1);
    tick(9);  chk("ins_e21_state", 32'(state), 2);
    tick(1);  chk("ins_e22_state", 32'(state), 3);
              chk("ins_e22_ready", 32'(mod_ready), 1);
              chk("ins_e22_seln", 32'(qsfp_mod_seln), 0);
              chk("ins_e22_lp", 32'(qsfp_lp_mode), 0);

    lpreq = 1; tick(1); chk("lp_req_hi", 32'(qsfp_lp_mode), 1);
    lpreq = 0; tick(1); chk("lp_req_lo", 32'(qsfp_lp_mode), 0);

    // Software reset from READY.
    sw = 1; tick(1); chk("sw_e0_state", 32'(state), 1);
                     chk("sw_e0_rstn", 32'(qsfp_rstn), 0);
    sw = 0;
    tick(4);  chk("sw_e4_state", 32'(state), 1);
    tick(1);  chk("sw_e5_state", 32'(state), 2);
    tick(9);  chk("sw_e14_state", 32'(state), 2);
    tick(1);  chk("sw_e15_state", 32'(state), 3);

    // Interrupt set, clear while still asserted, clear after release.
    intn = 0;
    tick(2);  chk("int_e1", 32'(int_pending), 0);
    tick(1);  chk("int_e2", 32'(int_pending), 1);
    iclr = 1; tick(1); iclr = 0;
    chk("int_clr_held", 32'(int_pending), 1);
    intn = 1; tick(3);
    chk("int_released", 32'(int_pending), 1);
    iclr = 1; tick(1); iclr = 0;
    chk("int_cleared", 32'(int_pending), 0);

    // Leave an interrupt pending, then remove the module during INIT_WAIT.
    intn = 0; tick(3); intn = 1;
    chk("int_again", 32'(int_pending), 1);
    sw = 1; tick(1); sw = 0;
    tick(5);  chk("rm_pre_state", 32'(state), 2);
    prsn = 1;
    tick(7);  chk("rm_e6_state", 32'(state), 2);
              chk("rm_e6_present", 32'(mod_present), 0);
    tick(1);  chk("rm_e7_state", 32'(state), 0);
              chk("rm_e7_rstn", 32'(qsfp_rstn), 0);
              chk("rm_e7_lp", 32'(qsfp_lp_mode), 1);
              chk("rm_e7_int", 32'(int_pending), 0);
    tick(3);

    // Reset mid-sequence aborts at once and restarts with full debounce.
    prsn = 0;
    tick(9);  chk("mid_pre_state", 32'(state), 1);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_rstn", 32'(qsfp_rstn), 0);
    chk("mid_rst_insert", 32'(insert_cnt), 0);
    chk("mid_rst_present", 32'(mod_present), 0);
    @(posedge clk); #1 rst_n = 1;
    tick(6);  chk("mid_e5_present", 32'(mod_present), 0);
    tick(1);  chk("mid_e6_present", 32'(mod_present), 1);
    tick(1);  chk("mid_e7_insert", 32'(insert_cnt), 1);

    // Insertion counter saturation.
    for (int i = 0; i < 256; i++) begin
      prsn = 1; tick(10);
      prsn = 0; tick(10);
      if (i == 252) chk("sat_254", 32'(insert_cnt), 254);
    end
    chk("sat_255", 32'(insert_cnt), 255);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
